// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit scheduler and its sample FIFO.
package i2s_pkg;

    localparam int FRAME_BITS = 32;
    localparam int CHAN_BITS  = 16;

    localparam logic [FRAME_BITS-1:0] ZERO_FRAME = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Word select for a given bit position: left channel first, then right.
    function automatic logic ws_for_bit(input logic [4:0] bit_idx);
        return bit_idx >= 5'(CHAN_BITS);
    endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with registered ready and occupancy; head is the oldest entry.
module i2s_sample_fifo
    import i2s_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [FRAME_BITS-1:0]   wr_data,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic                    pop,
    output logic [FRAME_BITS-1:0]   head,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [FRAME_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level_nxt;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (level == '0);
    assign do_push = wr_valid && wr_ready;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // NOTE: level_nxt is given a default before the branches so no latch is inferred.
    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + (AW + 1)'(1);
        end else if (do_pop && !do_push) begin
            level_nxt = level - (AW + 1)'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_ready <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_nxt;
            wr_ready <= (level_nxt != FULL_LEVEL);
        end
    end

    // NOTE: storage is not reset; occupancy and pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// I2S transmit sequencer: divides MasterCLK into the bit clock, picks each stereo frame
// from the sample FIFO or the test-tone input, and shifts it out MSB-first.
module i2s_frame_scheduler
    import i2s_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         MasterCLK,
    input  logic                         Reset_n,
    input  logic                         Enable,
    input  logic                         Mute,
    input  logic                         SrcSel,
    input  logic [FRAME_BITS-1:0]        WrData,
    input  logic                         WrValid,
    output logic                         WrReady,
    input  logic [FRAME_BITS-1:0]        TestData,
    input  logic                         UnderrunClr,
    output logic                         Underrun,
    output logic [$clog2(FIFO_DEPTH):0]  Level,
    output logic                         FrameSync,
    output logic                         I2S_CLK,
    output logic                         I2S_WS,
    output logic                         I2S_DATA
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

    state_t                state;
    logic [7:0]            div_cnt;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] next_frame;
    logic [FRAME_BITS-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  div_wrap;
    logic                  underrun_set;

    i2s_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (MasterCLK),
        .rst_n    (Reset_n),
        .wr_data  (WrData),
        .wr_valid (WrValid),
        .wr_ready (WrReady),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .level    (Level)
    );

    assign FrameSync    = (state == LOAD);
    assign fifo_pop     = (state == LOAD) && !SrcSel;
    assign underrun_set = (state == LOAD) && !SrcSel && fifo_empty;
    assign div_wrap     = (state == SHIFT) && (div_cnt == DIV_LAST);
    // The bit on the wire is always the top of the shift register.
    assign I2S_DATA     = shreg[FRAME_BITS-1];

    // Mute zeroes the payload only; the pop and underrun decisions are unaffected.
    always_comb begin
        next_frame = ZERO_FRAME;
        if (SrcSel) begin
            next_frame = TestData;
        end else if (!fifo_empty) begin
            next_frame = fifo_head;
        end
        if (Mute) begin
            next_frame = ZERO_FRAME;
        end
    end

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= ZERO_FRAME;
            I2S_CLK <= 1'b0;
            I2S_WS  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    shreg   <= ZERO_FRAME;
                    I2S_CLK <= 1'b0;
                    I2S_WS  <= 1'b0;
                    if (Enable) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    shreg   <= next_frame;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    I2S_WS  <= 1'b0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        I2S_CLK <= ~I2S_CLK;
                        // Falling toggle: advance to the next bit, or close the frame after bit 31.
                        if (I2S_CLK) begin
                            if (bit_cnt == LAST_BIT) begin
                                if (Enable) begin
                                    state <= LOAD;
                                end else begin
                                    state  <= IDLE;
                                    shreg  <= ZERO_FRAME;
                                    I2S_WS <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                                shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                                I2S_WS  <= ws_for_bit(bit_cnt + 5'd1);
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge MasterCLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Underrun <= 1'b0;
        end else if (underrun_set) begin
            Underrun <= 1'b1;
        end else if (UnderrunClr) begin
            Underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Randomized bench for i2s_frame_scheduler: a frame-level reference model predicts load
// timing, FIFO occupancy, underrun and frame content; a serial monitor checks the wire.
module tb_i2s_frame_scheduler;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LW         = $clog2(FIFO_DEPTH) + 1;
    localparam int FRAME_CYC  = 64 * CLK_DIV;

    logic          MasterCLK   = 1'b0;
    logic          Reset_n     = 1'b0;
    logic          Enable      = 1'b0;
    logic          Mute        = 1'b0;
    logic          SrcSel      = 1'b0;
    logic [31:0]   WrData      = '0;
    logic          WrValid     = 1'b0;
    logic [31:0]   TestData    = '0;
    logic          UnderrunClr = 1'b0;
    logic          WrReady;
    logic          Underrun;
    logic [LW-1:0] Level;
    logic          FrameSync;
    logic          I2S_CLK;
    logic          I2S_WS;
    logic          I2S_DATA;

    int n_tests = 0;
    int n_fail  = 0;

    i2s_frame_scheduler #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .MasterCLK   (MasterCLK),
        .Reset_n     (Reset_n),
        .Enable      (Enable),
        .Mute        (Mute),
        .SrcSel      (SrcSel),
        .WrData      (WrData),
        .WrValid     (WrValid),
        .WrReady     (WrReady),
        .TestData    (TestData),
        .UnderrunClr (UnderrunClr),
        .Underrun    (Underrun),
        .Level       (Level),
        .FrameSync   (FrameSync),
        .I2S_CLK     (I2S_CLK),
        .I2S_WS      (I2S_WS),
        .I2S_DATA    (I2S_DATA)
    );

    always #5 MasterCLK = ~MasterCLK;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model state, updated once per cycle at the falling MasterCLK edge.
    logic [31:0] m_fifo[$];
    logic [31:0] exp_q[$];
    bit          m_underrun = 1'b0;
    bit          m_idle     = 1'b1;
    longint      cyc        = 0;
    longint      m_load_at  = -1;
    longint      m_end_at   = -1;
    int          frames_seen = 0;

    always @(negedge MasterCLK) begin : model
        logic [31:0] frame;
        bit          in_load;
        bit          in_shift;
        bit          ready;
        bit          uflow;
        bit          exp_clk;
        longint      start;
        if (!Reset_n) begin
            m_fifo.delete();
            exp_q.delete();
            m_underrun = 1'b0;
            m_idle     = 1'b1;
            m_load_at  = -1;
            m_end_at   = -1;
        end else begin
            in_load  = (cyc == m_load_at);
            start    = m_end_at - FRAME_CYC + 1;
            in_shift = (m_end_at >= 0) && (cyc >= start) && (cyc <= m_end_at);
            exp_clk  = in_shift && (((cyc - start) / CLK_DIV) % 2 == 1);
            ready    = (m_fifo.size() < FIFO_DEPTH);

            check("frame_sync", 32'(FrameSync), 32'(in_load));
            check("i2s_clk", 32'(I2S_CLK), 32'(exp_clk));
            check("level", 32'(Level), 32'(m_fifo.size()));
            check("wr_ready", 32'(WrReady), 32'(ready));
            check("underrun", 32'(Underrun), 32'(m_underrun));
            if (m_idle) begin
                check("idle_ws", 32'(I2S_WS), 32'd0);
                check("idle_data", 32'(I2S_DATA), 32'd0);
            end

            uflow = 1'b0;
            if (in_load) begin
                frame = '0;
                if (SrcSel) begin
                    frame = TestData;
                end else if (m_fifo.size() > 0) begin
                    frame = m_fifo.pop_front();
                end else begin
                    uflow = 1'b1;
                end
                if (Mute) begin
                    frame = '0;
                end
                exp_q.push_back(frame);
                m_end_at = cyc + FRAME_CYC;
            end
            if (WrValid && ready) begin
                m_fifo.push_back(WrData);
            end
            if (uflow) begin
                m_underrun = 1'b1;
            end else if (UnderrunClr) begin
                m_underrun = 1'b0;
            end
            if (m_idle && Enable) begin
                m_idle    = 1'b0;
                m_load_at = cyc + 1;
            end else if (cyc == m_end_at) begin
                if (Enable) begin
                    m_load_at = cyc + 1;
                end else begin
                    m_idle = 1'b1;
                end
            end
        end
        cyc++;
    end

    // Serial monitor: samples DATA/WS on each bit-clock rise and checks whole frames.
    logic [31:0] mon_data = '0;
    logic [31:0] mon_ws   = '0;
    int          mon_bits = 0;
    logic        mon_prev = 1'b0;

    always @(negedge MasterCLK) begin : monitor
        if (!Reset_n) begin
            mon_bits = 0;
            mon_prev = 1'b0;
        end else begin
            if (I2S_CLK && !mon_prev) begin
                mon_data = {mon_data[30:0], I2S_DATA};
                mon_ws   = {mon_ws[30:0], I2S_WS};
                mon_bits++;
                if (mon_bits == 32) begin
                    mon_bits = 0;
                    frames_seen++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL frame_data: got %h, expected no frame", mon_data);
                    end else begin
                        check("frame_data", mon_data, exp_q.pop_front());
                    end
                    check("frame_ws", mon_ws, 32'h0000_FFFF);
                end
            end
            mon_prev = I2S_CLK;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge MasterCLK);
        #1;
    endtask

    task automatic wait_load(input string name);
        int i;
        for (i = 0; i < 3 * FRAME_CYC && cyc != m_load_at; i++) begin
            step(1);
        end
        if (cyc != m_load_at) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no LOAD, expected one within %0d cycles", name, 3 * FRAME_CYC);
        end
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 4 * FRAME_CYC && !(m_idle && exp_q.size() == 0); i++) begin
            step(1);
        end
        if (!(m_idle && exp_q.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got busy, expected idle within %0d cycles", name, 4 * FRAME_CYC);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_clk"}, 32'(I2S_CLK), 32'd0);
        check({tag, "_ws"}, 32'(I2S_WS), 32'd0);
        check({tag, "_data"}, 32'(I2S_DATA), 32'd0);
        check({tag, "_fsync"}, 32'(FrameSync), 32'd0);
        check({tag, "_underrun"}, 32'(Underrun), 32'd0);
        check({tag, "_level"}, 32'(Level), 32'd0);
        check({tag, "_wr_ready"}, 32'(WrReady), 32'd1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        step(3);
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        step(2);

        // Known pattern from the FIFO, single frame.
        WrData  = 32'hA5A5_5A5A;
        WrValid = 1'b1;
        step(1);
        WrValid = 1'b0;
        step(2);
        Enable = 1'b1;
        step(1);
        check("load_fsync", 32'(FrameSync), 32'd1);
        Enable = 1'b0;
        wait_idle("pattern_frame");

        // Empty-FIFO loads; clear pulsed on the second failing LOAD loses to the set.
        Enable = 1'b1;
        step(2);
        check("underrun_set", 32'(Underrun), 32'd1);
        wait_load("second_underrun_load");
        UnderrunClr = 1'b1;
        Enable      = 1'b0;
        step(1);
        UnderrunClr = 1'b0;
        check("underrun_set_wins", 32'(Underrun), 32'd1);
        wait_idle("underrun_frames");
        UnderrunClr = 1'b1;
        step(1);
        UnderrunClr = 1'b0;
        step(1);
        check("underrun_cleared", 32'(Underrun), 32'd0);

        // Five pushes into a four-deep FIFO.
        WrValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            WrData = $urandom;
            step(1);
        end
        WrValid = 1'b0;
        check("full_level", 32'(Level), 32'd4);
        check("full_ready", 32'(WrReady), 32'd0);
        Enable = 1'b1;
        step(1);
        Enable = 1'b0;
        step(1);
        check("after_pop_level", 32'(Level), 32'd3);
        check("after_pop_ready", 32'(WrReady), 32'd1);
        wait_idle("fifo_frame");

        // Test tone with Mute raised mid-frame: next frame is zero, FIFO untouched.
        SrcSel   = 1'b1;
        TestData = 32'h7FFF_8000;
        Enable   = 1'b1;
        step(1);
        step(40);
        Mute     = 1'b1;
        TestData = $urandom;
        wait_load("muted_load");
        Enable = 1'b0;
        step(1);
        Mute = 1'b0;
        wait_idle("tone_frames");
        check("tone_level", 32'(Level), 32'd3);
        SrcSel = 1'b0;

        // Drop Enable at bit 5: the frame completes, then no further loads.
        Enable = 1'b1;
        step(1);
        step(1 + 5 * 2 * CLK_DIV);
        Enable = 1'b0;
        wait_idle("enable_drop");
        step(2 * FRAME_CYC / 4);
        check("idle_after_drop", 32'(I2S_CLK), 32'd0);

        // Randomized traffic across several frames.
        Enable = 1'b1;
        for (int c = 0; c < 8 * FRAME_CYC; c++) begin
            WrValid     = ($urandom_range(0, 3) == 0);
            WrData      = $urandom;
            TestData    = $urandom;
            Mute        = ($urandom_range(0, 7) == 0);
            SrcSel      = ($urandom_range(0, 3) == 0);
            UnderrunClr = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 299) == 0) begin
                Enable = ~Enable;
            end
            step(1);
        end
        WrValid     = 1'b0;
        UnderrunClr = 1'b0;
        Mute        = 1'b0;
        SrcSel      = 1'b0;
        Enable      = 1'b0;
        wait_idle("random_traffic");

        // Asynchronous reset near bit 20, then a fresh frame from bit 0.
        WrValid = 1'b1;
        WrData  = $urandom;
        step(1);
        WrData  = $urandom;
        step(1);
        WrValid = 1'b0;
        Enable  = 1'b1;
        step(1);
        step(20 * 2 * CLK_DIV);
        @(posedge MasterCLK);
        #3;
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge MasterCLK);
        #1;
        Reset_n = 1'b1;
        WrValid = 1'b1;
        WrData  = 32'h1234_ABCD;
        step(1);
        WrValid = 1'b0;
        base = frames_seen;
        for (int i = 0; i < 3 * FRAME_CYC && frames_seen == base; i++) begin
            step(1);
        end
        check("frame_after_reset", 32'(frames_seen - base), 32'd1);
        Enable = 1'b0;
        wait_idle("after_reset");

        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
